vector_load_unit: RTL and testbench
===================================

VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter VEC_W, default 128: width of the assembled vector.
REQ-003 Parameter WORD_W, default 32: width of one memory word; NWORDS = VEC_W/WORD_W (4 at defaults).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to load one vector.
REQ-007 base_addr  in  32  byte address of word 0, sampled when start is accepted.
REQ-008 mem_addr  out  32  byte address of the current word request.
REQ-009 mem_rd  out  1  word read request, held until mem_valid.
REQ-010 mem_rdata  in  WORD_W  returned word, qualified by mem_valid.
REQ-011 mem_valid  in  1  memory response strobe.
REQ-012 writeData  out  VEC_W  assembled vector, wired to the vector register writeData port.
REQ-013 writeEn  out  1  one-cycle write strobe, wired to the vector register writeEn port.
REQ-014 busy  out  1  high from start acceptance until the writeEn cycle, inclusive.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, COMMIT; reset state IDLE.
REQ-016 IDLE: start=1 -> latch base_addr with bits [1:0] forced to 00, clear word index, go to FETCH next cycle; start=0 -> stay.
REQ-017 FETCH: mem_rd=1, mem_addr = latched base + 4*index (modulo 2^32, wrap permitted).
REQ-018 FETCH: a cycle with mem_valid=1 SHALL capture mem_rdata into lane index and increment index; mem_valid=0 SHALL hold mem_rd, mem_addr and index unchanged.
REQ-019 Lane mapping: word 0 -> writeData[VEC_W-1 -: WORD_W], word NWORDS-1 -> writeData[WORD_W-1:0] (big-endian lanes).
REQ-020 FETCH -> COMMIT on the cycle mem_valid captures word NWORDS-1.
REQ-021 COMMIT: writeEn=1 for exactly one cycle with the complete vector on writeData; next state IDLE.
REQ-022 Minimum latency: start at cycle 0 with mem_valid tied high -> writeEn at cycle 5 (4 FETCH cycles, then COMMIT).
REQ-023 Only one request is outstanding; mem_valid arriving in IDLE or COMMIT SHALL be ignored.
REQ-024 start asserted while busy=1 SHALL be ignored (not queued).
REQ-025 writeData SHALL change only on lane capture; after COMMIT it holds the last vector until the next capture.
REQ-026 mem_rd SHALL be 0 in IDLE and COMMIT; mem_addr is don't-care when mem_rd=0 but is driven to the latched base.
REQ-027 start in the COMMIT cycle is ignored; a new load starts on a start seen in IDLE.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, index 0, latched base 0, writeData 0, writeEn 0, mem_rd 0, busy 0.
REQ-029 Reset during FETCH SHALL abort the load; no writeEn is produced for the aborted vector.
REQ-030 After rst deasserts, the first accepted start SHALL behave exactly as in REQ-016.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, VEC_W/WORD_W defaults and the address stride constant (4).
REQ-032 No sub-module is required; the vector register stays a separate instance downstream in the datapath.

Verification
REQ-033 Reset, start=1, base=0x100, mem_valid tied 1, words 0x12345678, 0x90ABCDEF, 0x11223344, 0x55667788 -> addrs 0x100/104/108/10C, writeEn at cycle 5, writeData = 128'h1234567890ABCDEF1122334455667788.
REQ-034 Same load with mem_valid delayed by 3 cycles on word 2 -> mem_rd and mem_addr=0x108 held 4 cycles, writeEn at cycle 8, same vector.
REQ-035 base=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; base=0x103 -> addrs start 0x100.
REQ-036 start pulsed again in FETCH and in COMMIT -> ignored, exactly one writeEn; stray mem_valid in IDLE -> writeData unchanged.
REQ-037 rst asserted after word 1 is captured -> all outputs 0 asynchronously, no writeEn; a fresh load of all-0xFFFFFFFF words -> writeData = 128'hFFFF...FF.
REQ-038 Bench SHALL connect writeData/writeEn to the 128-bit vector register and check that the register read equals the expected vector one cycle after writeEn.

Source files
------------

// File: rtl/vector_load_unit_pkg.sv
// Shared types and constants for the vector load unit.
// Holds the FSM state encoding, default widths and the word stride.
package vector_load_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } vlu_state_t;

  localparam int VEC_W_DEF   = 128;
  localparam int WORD_W_DEF  = 32;
  localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/vector_load_unit.sv
// Fetches NWORDS consecutive memory words and assembles them
// into one big-endian-laned vector for the vector register file.
module vector_load_unit
  import vector_load_unit_pkg::*;
#(
  parameter int VEC_W  = VEC_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  output logic [31:0]       mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [VEC_W-1:0]  writeData,
  output logic              writeEn,
  output logic              busy
);

  localparam int NWORDS = VEC_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  vlu_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      base_q, base_d;
  logic [VEC_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = {base_addr[31:2], 2'b00};
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mem_valid) begin
          // word 0 lands in the most significant lane
          data_d[(NWORDS - 1 - int'(idx_q)) * WORD_W +: WORD_W] = mem_rdata;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd    = (state_q == FETCH);
  assign writeEn   = (state_q == COMMIT);
  assign busy      = (state_q != IDLE);
  assign writeData = data_q;
  assign mem_addr  = mem_rd
                   ? base_q + 32'(idx_q) * 32'(ADDR_STRIDE)
                   : base_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed and randomized bench for vector_load_unit with a
// downstream vector register model and a spec-level reference.
module tb_vector_load_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [31:0]  mem_addr;
  logic         mem_rd;
  logic [31:0]  mem_rdata;
  logic         mem_valid;
  logic [127:0] writeData;
  logic         writeEn;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  logic [127:0] vreg;
  logic [31:0]  wd [4];
  int           dl [4];

  always #5 clk = ~clk;

  vector_load_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .writeData (writeData),
    .writeEn   (writeEn),
    .busy      (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vreg <= '0;
    else if (writeEn) vreg <= writeData;
  end

  always @(posedge clk) if (writeEn) we_cnt++;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] ref_vec();
    return {wd[0], wd[1], wd[2], wd[3]};
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] b,
                                           input int i);
    return (b & 32'hFFFF_FFFC) + 32'(i * 4);
  endfunction

  task automatic do_load(input logic [31:0] base,
                         input bit poke_start,
                         input string nm);
    logic [127:0] prev;
    int           we0;
    prev = writeData;
    we0  = we_cnt;
    start     = 1'b1;
    base_addr = base;
    mem_valid = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d <= dl[i]; d++) begin
        mem_valid = (d == dl[i]);
        mem_rdata = mem_valid ? wd[i] : $urandom;
        start     = poke_start && (i == 1) && (d == 0);
        base_addr = $urandom;
        chk({nm, ".rd"}, 128'(mem_rd), 128'(1));
        chk({nm, ".addr"}, 128'(mem_addr), 128'(ref_addr(base, i)));
        chk({nm, ".we_fetch"}, 128'(writeEn), 128'(0));
        chk({nm, ".busy"}, 128'(busy), 128'(1));
        if (i == 0)
          chk({nm, ".hold"}, writeData, prev);
        step();
      end
    end
    mem_valid = 1'b0;
    start     = poke_start;
    chk({nm, ".we"}, 128'(writeEn), 128'(1));
    chk({nm, ".data"}, writeData, ref_vec());
    chk({nm, ".rd_commit"}, 128'(mem_rd), 128'(0));
    step();
    start = 1'b0;
    chk({nm, ".we_off"}, 128'(writeEn), 128'(0));
    chk({nm, ".idle"}, 128'(busy), 128'(0));
    chk({nm, ".vreg"}, vreg, ref_vec());
    mem_valid = 1'b1;
    mem_rdata = $urandom;
    step();
    mem_valid = 1'b0;
    step();
    chk({nm, ".stray"}, writeData, ref_vec());
    chk({nm, ".we_cnt"}, 128'(we_cnt - we0), 128'(1));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    mem_rdata = '0;
    mem_valid = 1'b0;
    #1;
    chk("rst.rd", 128'(mem_rd), 128'(0));
    chk("rst.we", 128'(writeEn), 128'(0));
    chk("rst.busy", 128'(busy), 128'(0));
    chk("rst.data", writeData, 128'(0));
    chk("rst.addr", 128'(mem_addr), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle.busy", 128'(busy), 128'(0));

    wd = '{32'h12345678, 32'h90ABCDEF, 32'h11223344, 32'h55667788};
    dl = '{0, 0, 0, 0};
    do_load(32'h100, 1'b0, "basic");
    chk("basic.lit", vreg, 128'h1234567890ABCDEF1122334455667788);

    dl = '{0, 0, 3, 0};
    do_load(32'h100, 1'b0, "delay");

    dl = '{0, 0, 0, 0};
    wd = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_load(32'hFFFF_FFF8, 1'b0, "wrap");
    do_load(32'h103, 1'b0, "align");

    dl = '{1, 0, 2, 1};
    do_load(32'h400, 1'b1, "pokes");

    start     = 1'b1;
    base_addr = 32'h200;
    step();
    start     = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD0001;
    step();
    mem_rdata = 32'hDEAD0002;
    step();
    mem_valid = 1'b0;
    chk("abort.pre", 128'(mem_addr), 128'(32'h208));
    begin
      int we0;
      we0 = we_cnt;
      #2 rst = 1'b1;
      #1;
      chk("abort.rd", 128'(mem_rd), 128'(0));
      chk("abort.busy", 128'(busy), 128'(0));
      chk("abort.we", 128'(writeEn), 128'(0));
      chk("abort.data", writeData, 128'(0));
      chk("abort.addr", 128'(mem_addr), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      step();
      step();
      chk("abort.no_we", 128'(we_cnt - we0), 128'(0));
    end

    wd = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    dl = '{0, 0, 0, 0};
    do_load(32'h300, 1'b0, "ones");

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) begin
        wd[i] = $urandom;
        dl[i] = int'($urandom_range(0, 3));
      end
      do_load($urandom, ($urandom_range(0, 1) == 1), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
